uart_rx_frame_ctrl: RTL

//  - UART receive frame controller. Consumes the 16x sample_tick from the RX baud generator and sequences

---
 rtl/uart_rx_frame_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start qualification, mid-bit sampling, LSB-first shift-in, stop check.
// Optional even parity via `define UART_RX_PARITY_EN (adds a PARITY state between DATA and STOP).
module uart_rx_frame_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_e;

  state_e               state_q;
  logic [1:0]           rx_sync_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 busy_q;
  logic                 rx_s;

  assign rx_s = rx_sync_q[1];

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic parity_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_sync_q    <= 2'b11;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_sync_q   <= {rx_sync_q[0], rx_i};
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (sample_tick_i && !rx_s) begin
            state_q    <= START;
            tick_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        // Half a bit into the start bit: still low means a real frame, else a glitch.
        START: begin
          if (sample_tick_i) begin
            if (tick_cnt_q == HALF_M1) begin
              tick_cnt_q <= '0;
              if (!rx_s) begin
                state_q   <= DATA;
                bit_idx_q <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (sample_tick_i) begin
            if (tick_cnt_q == FULL_M1) begin
              shreg_q    <= {rx_s, shreg_q[DATA_BITS-1:1]};
              tick_cnt_q <= '0;
              bit_idx_q  <= bit_idx_q + 1'b1;
              if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_tick_i) begin
            if (tick_cnt_q == FULL_M1) begin
              par_q      <= rx_s;
              tick_cnt_q <= '0;
              state_q    <= STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
`endif
        // Returning to IDLE on the stop sample lets a directly following start bit be caught.
        STOP: begin
          if (sample_tick_i) begin
            if (tick_cnt_q == FULL_M1) begin
              tick_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_q ^ (^shreg_q);
`endif
              if (rx_s) begin
                rx_data_q  <= shreg_q;
                rx_valid_q <= 1'b1;
                state_q    <= IDLE;
                busy_q     <= 1'b0;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= BRK_WAIT;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        BRK_WAIT: begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
